mips_cpu_bus: RTL and testbench

MIPS_CPU_BUS -- requirements
Module: mips_cpu_bus

---
 rtl/mips_cpu_bus.sv | 236 +++++++++++++++++++++++
 tb/tb_mips_cpu_bus.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_cpu_bus.sv
// Multicycle, non-pipelined MIPS-I subset core on a single memory bus with waitrequest stalls.
// One instruction walks fetch -> decode -> execute (-> mem -> writeback for loads) -> fetch.
module mips_cpu_bus (
  input  logic        clk,
  input  logic        reset,
  output logic        active,
  output logic [31:0] register_v0,
  output logic [31:0] address,
  output logic        write,
  output logic        read,
  input  logic        waitrequest,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic [31:0] readdata
);
  localparam logic [31:0] ResetPc = 32'hBFC0_0000;

  typedef enum logic [2:0] {StFetch, StDecode, StExec, StMem, StWb, StHalted} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d, ir_q, ir_d, a_q, a_d, b_q, b_d, tgt_q, tgt_d;
  logic        dly_q, dly_d, rd_q, rd_d, wr_q, wr_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] gpr_q [32];

  logic [5:0]  op, funct;
  logic [4:0]  rt, rd, sh;
  logic [31:0] simm, zimm, pc_plus4, seq_pc;

  assign op       = ir_q[31:26];
  assign rt       = ir_q[20:16];
  assign rd       = ir_q[15:11];
  assign sh       = ir_q[10:6];
  assign funct    = ir_q[5:0];
  assign simm     = {{16{ir_q[15]}}, ir_q[15:0]};
  assign zimm     = {16'h0000, ir_q[15:0]};
  assign pc_plus4 = pc_q + 32'd4;
  // A pending taken branch redirects the instruction after its delay slot.
  assign seq_pc   = dly_q ? tgt_q : pc_plus4;

  logic [31:0] result, jtarget;
  logic        wb_en, take, is_lw, is_sw;
  logic [4:0]  wb_reg;

  always_comb begin
    result  = '0;
    wb_en   = 1'b0;
    wb_reg  = rt;
    take    = 1'b0;
    jtarget = pc_plus4 + {simm[29:0], 2'b00};
    is_lw   = (op == 6'h23);
    is_sw   = (op == 6'h2b);
    case (op)
      6'h00: begin
        wb_en  = 1'b1;
        wb_reg = rd;
        case (funct)
          6'h21:   result = a_q + b_q;
          6'h23:   result = a_q - b_q;
          6'h24:   result = a_q & b_q;
          6'h25:   result = a_q | b_q;
          6'h26:   result = a_q ^ b_q;
          6'h2a:   result = {31'b0, $signed(a_q) < $signed(b_q)};
          6'h2b:   result = {31'b0, a_q < b_q};
          6'h00:   result = b_q << sh;
          6'h02:   result = b_q >> sh;
          6'h03:   result = $unsigned($signed(b_q) >>> sh);
          6'h08: begin
            wb_en   = 1'b0;
            take    = 1'b1;
            jtarget = a_q;
          end
          6'h09: begin
            result  = pc_q + 32'd8;
            take    = 1'b1;
            jtarget = a_q;
          end
          default: wb_en = 1'b0;
        endcase
      end
      6'h09: begin wb_en = 1'b1; result = a_q + simm; end
      6'h0a: begin wb_en = 1'b1; result = {31'b0, $signed(a_q) < $signed(simm)}; end
      6'h0b: begin wb_en = 1'b1; result = {31'b0, a_q < simm}; end
      6'h0c: begin wb_en = 1'b1; result = a_q & zimm; end
      6'h0d: begin wb_en = 1'b1; result = a_q | zimm; end
      6'h0e: begin wb_en = 1'b1; result = a_q ^ zimm; end
      6'h0f: begin wb_en = 1'b1; result = {ir_q[15:0], 16'h0000}; end
      6'h04: take = (a_q == b_q);
      6'h05: take = (a_q != b_q);
      6'h02: begin take = 1'b1; jtarget = {pc_plus4[31:28], ir_q[25:0], 2'b00}; end
      6'h03: begin
        take    = 1'b1;
        jtarget = {pc_plus4[31:28], ir_q[25:0], 2'b00};
        wb_en   = 1'b1;
        wb_reg  = 5'd31;
        result  = pc_q + 32'd8;
      end
      default: ;
    endcase
  end

  logic        rf_we, go_fetch;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd, go_pc;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    a_d      = a_q;
    b_d      = b_q;
    tgt_d    = tgt_q;
    dly_d    = dly_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    rf_we    = 1'b0;
    rf_wa    = rt;
    rf_wd    = result;
    go_fetch = 1'b0;
    go_pc    = pc_q;
    unique case (state_q)
      StFetch: begin
        // Right after reset the fetch request has not been issued yet.
        if (!rd_q) begin
          rd_d   = 1'b1;
          addr_d = pc_q;
          be_d   = 4'hF;
        end else if (!waitrequest) begin
          rd_d    = 1'b0;
          be_d    = 4'h0;
          state_d = StDecode;
        end
      end
      StDecode: begin
        ir_d    = readdata;
        a_d     = gpr_q[readdata[25:21]];
        b_d     = gpr_q[readdata[20:16]];
        state_d = StExec;
      end
      StExec: begin
        pc_d  = seq_pc;
        dly_d = take;
        if (take) tgt_d = jtarget;
        if (is_lw || is_sw) begin
          state_d = StMem;
          addr_d  = a_q + simm;
          rd_d    = is_lw;
          wr_d    = is_sw;
          wdata_d = b_q;
          be_d    = 4'hF;
        end else begin
          rf_we    = wb_en;
          rf_wa    = wb_reg;
          go_fetch = 1'b1;
          go_pc    = seq_pc;
        end
      end
      StMem: begin
        if (!waitrequest) begin
          rd_d = 1'b0;
          wr_d = 1'b0;
          be_d = 4'h0;
          if (rd_q) state_d = StWb;
          else go_fetch = 1'b1;
        end
      end
      StWb: begin
        rf_we    = 1'b1;
        rf_wd    = readdata;
        go_fetch = 1'b1;
      end
      default: ;
    endcase
    if (go_fetch) begin
      if (go_pc == 32'h0) begin
        state_d = StHalted;
      end else begin
        state_d = StFetch;
        rd_d    = 1'b1;
        addr_d  = go_pc;
        be_d    = 4'hF;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StFetch;
      pc_q    <= ResetPc;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      tgt_q   <= '0;
      dly_q   <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= ResetPc;
      wdata_q <= '0;
      be_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      tgt_q   <= tgt_d;
      dly_q   <= dly_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) gpr_q[i] <= '0;
    end else if (rf_we && (rf_wa != 5'd0)) begin
      gpr_q[rf_wa] <= rf_wd;
    end
  end

  assign active      = (state_q != StHalted);
  assign register_v0 = gpr_q[2];
  assign address     = addr_q;
  assign read        = rd_q;
  assign write       = wr_q;
  assign writedata   = wdata_q;
  assign byteenable  = be_q;

endmodule

// File: tb/tb_mips_cpu_bus.sv
// Bench for mips_cpu_bus: bus slave with programmable stalls plus an instruction-level
// reference interpreter; directed programs, random programs and a mid-run reset.
module tb_mips_cpu_bus;
  localparam logic [31:0] ResetPc = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        waitrequest = 1'b0;
  logic [31:0] readdata = '0;
  logic        active, write, read;
  logic [31:0] register_v0, address, writedata;
  logic [3:0]  byteenable;

  mips_cpu_bus dut (
    .clk        (clk),
    .reset      (reset),
    .active     (active),
    .register_v0(register_v0),
    .address    (address),
    .write      (write),
    .read       (read),
    .waitrequest(waitrequest),
    .writedata  (writedata),
    .byteenable (byteenable),
    .readdata   (readdata)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] prog [64];
  logic [31:0] mem_dut [256];
  logic [31:0] mem_ref [256];
  logic [31:0] st_addr [$];
  logic [31:0] st_data [$];
  logic [31:0] exp_addr [$];
  logic [31:0] exp_data [$];
  logic [5:0]  rops [10];
  logic [5:0]  iops [7];
  int          wait_mode = 0;
  int          bus_err = 0;
  logic        pend = 1'b0;
  logic        p_rd = 1'b0;
  logic [31:0] p_addr = '0;
  logic [31:0] p_data = '0;
  int          wait_left = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] prog_word(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - ResetPc;
    if (off < 32'd256) return prog[off[7:2]];
    return 32'h0;
  endfunction

  function automatic logic [31:0] bus_word(input logic [31:0] addr);
    if (addr >= ResetPc) return prog_word(addr);
    return mem_dut[addr[9:2]];
  endfunction

  // Bus slave: decides waitrequest for the coming edge, completes accepted transfers.
  always @(negedge clk) begin
    if (reset) begin
      pend        = 1'b0;
      waitrequest = 1'b0;
      wait_left   = 0;
    end else begin
      if (pend && !waitrequest) begin
        if (p_rd) readdata = bus_word(p_addr);
        else begin
          mem_dut[p_addr[9:2]] = p_data;
          st_addr.push_back(p_addr);
          st_data.push_back(p_data);
        end
        pend = 1'b0;
      end else if (pend && !(read == p_rd && write == !p_rd && address == p_addr &&
                             (p_rd || writedata == p_data))) begin
        bus_err++;
      end
      if ((read && write) || ((read || write) && (address[1:0] != 2'b00 || byteenable != 4'hF)))
        bus_err++;
      if (!pend && (read || write)) begin
        pend   = 1'b1;
        p_rd   = read;
        p_addr = address;
        p_data = writedata;
        case (wait_mode)
          0:       wait_left = 0;
          1:       wait_left = (read && address >= ResetPc) ? 3 : 0;
          default: wait_left = int'($urandom_range(0, 2));
        endcase
      end
      waitrequest = pend && (wait_left > 0);
      if (wait_left > 0) wait_left--;
    end
  end

  // ISA-level interpreter: two-PC model of the delay slot, halts when PC reaches 0.
  task automatic ref_run(output logic [31:0] v0);
    logic [31:0] r [32];
    logic [31:0] pc, npc, nnpc, ins, a, b, se, ze, res, ea;
    logic [4:0]  wa;
    logic        we;
    for (int i = 0; i < 32; i++) r[i] = '0;
    for (int i = 0; i < 256; i++) mem_ref[i] = '0;
    exp_addr.delete();
    exp_data.delete();
    pc  = ResetPc;
    npc = pc + 32'd4;
    for (int step = 0; step < 4000 && pc != 32'h0; step++) begin
      ins  = prog_word(pc);
      a    = r[ins[25:21]];
      b    = r[ins[20:16]];
      se   = {{16{ins[15]}}, ins[15:0]};
      ze   = {16'h0, ins[15:0]};
      ea   = a + se;
      nnpc = npc + 32'd4;
      we   = 1'b1;
      wa   = ins[20:16];
      res  = '0;
      case (ins[31:26])
        6'h00: begin
          wa = ins[15:11];
          case (ins[5:0])
            6'h21: res = a + b;
            6'h23: res = a - b;
            6'h24: res = a & b;
            6'h25: res = a | b;
            6'h26: res = a ^ b;
            6'h2a: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            6'h2b: res = (a < b) ? 32'd1 : 32'd0;
            6'h00: res = b << ins[10:6];
            6'h02: res = b >> ins[10:6];
            6'h03: res = $unsigned($signed(b) >>> ins[10:6]);
            6'h08: begin we = 1'b0; nnpc = a; end
            6'h09: begin res = pc + 32'd8; nnpc = a; end
            default: we = 1'b0;
          endcase
        end
        6'h09: res = a + se;
        6'h0a: res = ($signed(a) < $signed(se)) ? 32'd1 : 32'd0;
        6'h0b: res = (a < se) ? 32'd1 : 32'd0;
        6'h0c: res = a & ze;
        6'h0d: res = a | ze;
        6'h0e: res = a ^ ze;
        6'h0f: res = ze << 16;
        6'h23: res = mem_ref[ea[9:2]];
        6'h2b: begin
          we = 1'b0;
          mem_ref[ea[9:2]] = b;
          exp_addr.push_back(ea);
          exp_data.push_back(b);
        end
        6'h04: begin we = 1'b0; if (a == b) nnpc = npc + (se << 2); end
        6'h05: begin we = 1'b0; if (a != b) nnpc = npc + (se << 2); end
        6'h02: begin we = 1'b0; nnpc = {npc[31:28], ins[25:0], 2'b00}; end
        6'h03: begin wa = 5'd31; res = pc + 32'd8; nnpc = {npc[31:28], ins[25:0], 2'b00}; end
        default: we = 1'b0;
      endcase
      if (we && wa != 5'd0) r[wa] = res;
      pc  = npc;
      npc = nnpc;
    end
    v0 = r[2];
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 64; i++) prog[i] = 32'h0;
  endtask

  task automatic gen_random();
    int          n, i, kind;
    bit          last_br;
    logic [4:0]  ra, rb, rc;
    clear_prog();
    n       = int'($urandom_range(10, 30));
    i       = 0;
    last_br = 1'b0;
    while (i < n) begin
      kind = int'($urandom_range(0, 9));
      ra   = 5'($urandom_range(0, 7));
      rb   = 5'($urandom_range(0, 7));
      rc   = 5'($urandom_range(0, 7));
      if (kind == 9 && !last_br && i <= n - 4) begin
        prog[i] = enc_i(($urandom_range(0, 1) != 0) ? 6'h04 : 6'h05, ra, rb,
                        16'($urandom_range(0, 2)));
        last_br = 1'b1;
      end else begin
        last_br = 1'b0;
        if (kind <= 2) prog[i] = enc_r(ra, rb, rc, 5'($urandom()), rops[$urandom_range(0, 9)]);
        else if (kind <= 6) prog[i] = enc_i(iops[$urandom_range(0, 6)], ra, rb, 16'($urandom()));
        else if (kind == 7) prog[i] = enc_i(6'h2b, 5'd0, rb, 16'($urandom_range(0, 255) * 4));
        else prog[i] = enc_i(6'h23, 5'd0, rb, 16'($urandom_range(0, 255) * 4));
      end
      i++;
    end
    // Fold every scratch register into $2 so the result is visible.
    for (int k = 1; k < 8; k++) begin
      if (k != 2) begin
        prog[i] = enc_r(5'd2, 5'(k), 5'd2, 5'd0, 6'h21);
        i++;
      end
    end
    prog[i]   = 32'h0000_0008;
    prog[i+1] = 32'h0;
  endtask

  task automatic apply_reset(input string tag);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check({tag, " rst active"}, 32'(active), 32'd1);
    check({tag, " rst read"}, 32'(read), 32'd0);
    check({tag, " rst write"}, 32'(write), 32'd0);
    check({tag, " rst be"}, 32'(byteenable), 32'd0);
    check({tag, " rst wdata"}, writedata, 32'd0);
    check({tag, " rst addr"}, address, ResetPc);
    check({tag, " rst v0"}, register_v0, 32'd0);
    for (int i = 0; i < 256; i++) mem_dut[i] = '0;
    st_addr.delete();
    st_data.delete();
    bus_err = 0;
    @(negedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic run_prog(input string tag, input int mode, input int abort_at,
                          output logic [31:0] v0_dut);
    logic [31:0] ev0;
    bit          done;
    ref_run(ev0);
    wait_mode = mode;
    apply_reset(tag);
    if (abort_at > 0) begin
      repeat (abort_at) @(posedge clk);
      apply_reset({tag, " abort"});
    end
    done = 1'b0;
    for (int c = 0; c < 5000 && !done; c++) begin
      @(posedge clk);
      #1 done = !active;
    end
    check({tag, " halt"}, 32'(done), 32'd1);
    check({tag, " v0"}, register_v0, ev0);
    check({tag, " nstores"}, 32'(st_addr.size()), 32'(exp_addr.size()));
    for (int k = 0; k < st_addr.size() && k < exp_addr.size(); k++) begin
      check($sformatf("%s st%0d addr", tag, k), st_addr[k], exp_addr[k]);
      check($sformatf("%s st%0d data", tag, k), st_data[k], exp_data[k]);
    end
    check({tag, " bus protocol"}, 32'(bus_err), 32'd0);
    v0_dut = register_v0;
    repeat (4) @(posedge clk);
    #1;
    check({tag, " halted idle"}, {29'd0, read, write, active}, 32'd0);
    check({tag, " v0 held"}, register_v0, ev0);
  endtask

  initial begin
    logic [31:0] v, jaddr;
    rops = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h2a, 6'h2b, 6'h00, 6'h02, 6'h03};
    iops = '{6'h09, 6'h0c, 6'h0d, 6'h0e, 6'h0a, 6'h0b, 6'h0f};

    clear_prog();
    prog[0] = enc_i(6'h09, 5'd0, 5'd2, 16'h1234);
    prog[1] = 32'h0000_0008;
    run_prog("addiu", 0, 0, v);
    check("addiu v0 const", v, 32'h0000_1234);
    run_prog("fetch stall", 1, 0, v);
    check("fetch stall v0 const", v, 32'h0000_1234);

    clear_prog();
    prog[0] = enc_i(6'h0f, 5'd0, 5'd3, 16'hDEAD);
    prog[1] = enc_i(6'h0d, 5'd3, 5'd3, 16'hBEEF);
    prog[2] = enc_i(6'h2b, 5'd0, 5'd3, 16'h0100);
    prog[3] = enc_i(6'h23, 5'd0, 5'd2, 16'h0100);
    prog[4] = 32'h0000_0008;
    run_prog("lui sw lw", 0, 0, v);
    check("sw lw v0 const", v, 32'hDEAD_BEEF);
    check("sw count const", 32'(st_data.size()), 32'd1);
    if (st_data.size() >= 1) begin
      check("sw data const", st_data[0], 32'hDEAD_BEEF);
      check("sw addr const", st_addr[0], 32'h0000_0100);
    end

    clear_prog();
    prog[0] = enc_i(6'h09, 5'd0, 5'd2, 16'hFFFF);
    prog[1] = enc_i(6'h09, 5'd2, 5'd2, 16'h0001);
    prog[2] = 32'h0000_0008;
    run_prog("wrap", 2, 0, v);
    check("wrap v0 const", v, 32'h0);

    clear_prog();
    prog[0] = enc_i(6'h04, 5'd0, 5'd0, 16'h0002);
    prog[1] = enc_i(6'h09, 5'd0, 5'd2, 16'h0005);
    prog[2] = enc_i(6'h09, 5'd2, 5'd2, 16'h0064);
    prog[3] = enc_i(6'h09, 5'd2, 5'd2, 16'h0007);
    prog[4] = 32'h0000_0008;
    run_prog("beq slot", 0, 0, v);
    check("beq slot v0 const", v, 32'd12);

    // JAL over two skipped words, unknown opcode at the target, then link folded into $2.
    clear_prog();
    jaddr   = ResetPc + 32'h10;
    prog[0] = {6'h03, jaddr[27:2]};
    prog[1] = enc_i(6'h09, 5'd0, 5'd2, 16'h0001);
    prog[2] = enc_i(6'h09, 5'd2, 5'd2, 16'h0040);
    prog[3] = enc_i(6'h09, 5'd2, 5'd2, 16'h0040);
    prog[4] = 32'hFC00_0000;
    prog[5] = enc_r(5'd2, 5'd31, 5'd2, 5'd0, 6'h21);
    prog[6] = 32'h0000_0008;
    run_prog("jal", 2, 0, v);
    check("jal v0 const", v, 32'hBFC0_0009);

    clear_prog();
    prog[0] = enc_i(6'h0f, 5'd0, 5'd5, 16'hBFC0);
    prog[1] = enc_i(6'h0d, 5'd5, 5'd5, 16'h0018);
    prog[2] = enc_r(5'd5, 5'd0, 5'd4, 5'd0, 6'h09);
    prog[3] = enc_i(6'h09, 5'd0, 5'd2, 16'h0003);
    prog[4] = enc_i(6'h09, 5'd2, 5'd2, 16'h0100);
    prog[5] = enc_i(6'h09, 5'd2, 5'd2, 16'h0100);
    prog[6] = enc_r(5'd2, 5'd4, 5'd2, 5'd0, 6'h21);
    prog[7] = 32'h0000_0008;
    run_prog("jalr", 1, 0, v);
    check("jalr v0 const", v, 32'hBFC0_0013);

    for (int t = 0; t < 20; t++) begin
      gen_random();
      run_prog($sformatf("rand%0d", t), t % 3, 0, v);
    end

    gen_random();
    run_prog("mid reset", 2, 37, v);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
